// File: rtl/cam_capture_multi.sv
// Multi-format OV7670 pixel capture in the camera pclk domain.
// Registers the camera pins once, tracks frame/line framing with a small FSM,
// assembles byte pairs into pixels (RGB444, RGB565 or Y-only), decimates by
// 1/2/4 on both axes and pushes kept pixels into the async FIFO write port.
module cam_capture_multi #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned EXP_WIDTH  = 640,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_pclk,
  input  logic                  i_rstn,
  input  logic                  i_cfg_done,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic [7:0]            i_data,
  input  logic [1:0]            i_mode,
  input  logic [1:0]            i_decim,
  input  logic                  i_full,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt,
  output logic                  o_line_err
);

  localparam int unsigned IDX_W = 16;
  localparam int unsigned PIX_W = 16;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    WAIT_VS  = 2'd1,
    VSYNC    = 2'd2,
    ACTIVE   = 2'd3
  } state_t;

  state_t state, state_d;

  logic             cfg_r;
  logic             vs_r, vs_q;
  logic             href_r, href_q;
  logic [7:0]       data_r;
  logic [1:0]       mode_r, decim_r;
  logic             full_r;

  logic [1:0]       mode_l, decim_l;
  logic             phase;
  logic [7:0]       hi_q;
  logic [IDX_W-1:0] pix_idx;
  logic [IDX_W-1:0] line_idx;

  logic             vs_rise_c, vs_fall_c;
  logic             sof_c, eof_c, enter_active_c;
  logic             act_c, beat_c, pix_done_c, keep_c, wr_c, drop_c;
  logic             href_fall_c, line_bad_c;
  logic [IDX_W-1:0] mask_c;
  logic [PIX_W-1:0] pix_c;

  // Single register stage on every camera-side input.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      cfg_r   <= 1'b0;
      vs_r    <= 1'b0;
      vs_q    <= 1'b0;
      href_r  <= 1'b0;
      href_q  <= 1'b0;
      data_r  <= 8'h00;
      mode_r  <= 2'd0;
      decim_r <= 2'd0;
      full_r  <= 1'b0;
    end else begin
      cfg_r   <= i_cfg_done;
      vs_r    <= i_vsync;
      vs_q    <= vs_r;
      href_r  <= i_href;
      href_q  <= href_r;
      data_r  <= i_data;
      mode_r  <= i_mode;
      decim_r <= i_decim;
      full_r  <= i_full;
    end
  end

  assign vs_rise_c = vs_r & ~vs_q;
  assign vs_fall_c = ~vs_r & vs_q;

  // Frame-tracking FSM state register.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) state <= WAIT_CFG;
    else         state <= state_d;
  end

  // Next state plus frame-boundary strobes; losing config aborts silently.
  always_comb begin
    state_d        = state;
    sof_c          = 1'b0;
    eof_c          = 1'b0;
    enter_active_c = 1'b0;
    if (!cfg_r) begin
      state_d = WAIT_CFG;
    end else begin
      case (state)
        WAIT_CFG: state_d = WAIT_VS;
        WAIT_VS: begin
          if (vs_rise_c) begin
            state_d = VSYNC;
            sof_c   = 1'b1;
          end
        end
        VSYNC: begin
          if (vs_fall_c) begin
            state_d        = ACTIVE;
            enter_active_c = 1'b1;
          end
        end
        ACTIVE: begin
          if (vs_rise_c) begin
            state_d = VSYNC;
            sof_c   = 1'b1;
            eof_c   = 1'b1;
          end
        end
        default: state_d = WAIT_CFG;
      endcase
    end
  end

  // Pixel assembly, decimation decision and line-length check.
  always_comb begin
    act_c       = (state == ACTIVE) && cfg_r;
    beat_c      = act_c && href_r;
    pix_done_c  = beat_c && phase;
    href_fall_c = act_c && !href_r && href_q;
    case (decim_l)
      2'd1:    mask_c = IDX_W'(1);
      2'd2:    mask_c = IDX_W'(3);
      default: mask_c = '0;
    endcase
    case (mode_l)
      2'd1:    pix_c = {hi_q, data_r};
      2'd2:    pix_c = {8'h00, hi_q};
      default: pix_c = {4'h0, hi_q[7:4], hi_q[2:0], data_r[7], data_r[4:1]};
    endcase
    keep_c     = pix_done_c && ((pix_idx & mask_c) == '0) && ((line_idx & mask_c) == '0);
    wr_c       = keep_c && !full_r;
    drop_c     = keep_c && full_r;
    line_bad_c = href_fall_c && ((pix_idx != IDX_W'(EXP_WIDTH)) || phase);
  end

  // Frame-wide format/decimation latched as the active region begins.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      mode_l  <= 2'd0;
      decim_l <= 2'd0;
    end else if (enter_active_c) begin
      mode_l  <= mode_r;
      decim_l <= decim_r;
    end
  end

  // Byte phase and per-line pixel index; both restart whenever href is low.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      phase   <= 1'b0;
      hi_q    <= 8'h00;
      pix_idx <= '0;
    end else if (beat_c) begin
      phase <= ~phase;
      if (!phase) hi_q    <= data_r;
      else        pix_idx <= pix_idx + IDX_W'(1);
    end else begin
      phase   <= 1'b0;
      pix_idx <= '0;
    end
  end

  // Line index within the frame, advanced at each line end.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn)             line_idx <= '0;
    else if (enter_active_c) line_idx <= '0;
    else if (href_fall_c)    line_idx <= line_idx + IDX_W'(1);
  end

  // FIFO write port and frame pulses; wdata holds between writes.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_wr        <= 1'b0;
      o_wdata     <= '0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_wr  <= wr_c;
      o_sof <= sof_c;
      o_eof <= eof_c;
      if (wr_c)  o_wdata     <= DATA_WIDTH'(pix_c);
      if (eof_c) o_frame_cnt <= o_frame_cnt + CNT_WIDTH'(1);
    end
  end

  // Drop counter: cleared at frame start, a same-cycle drop still counts.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_drop_cnt <= '0;
    end else if (sof_c) begin
      o_drop_cnt <= drop_c ? CNT_WIDTH'(1) : '0;
    end else if (drop_c && (o_drop_cnt != '1)) begin
      o_drop_cnt <= o_drop_cnt + CNT_WIDTH'(1);
    end
  end

  // Sticky per-frame line-length error.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn)         o_line_err <= 1'b0;
    else if (sof_c)      o_line_err <= line_bad_c;
    else if (line_bad_c) o_line_err <= 1'b1;
  end

endmodule

// File: tb/tb_cam_capture_multi.sv
// Directed bench for cam_capture_multi with a write-data scoreboard.
module tb_cam_capture_multi;

  localparam int unsigned DW = 16;
  localparam int unsigned EW = 4;
  localparam int unsigned CW = 16;

  logic          i_pclk = 1'b0;
  logic          i_rstn;
  logic          i_cfg_done;
  logic          i_vsync;
  logic          i_href;
  logic [7:0]    i_data;
  logic [1:0]    i_mode;
  logic [1:0]    i_decim;
  logic          i_full;
  logic          o_wr;
  logic [DW-1:0] o_wdata;
  logic          o_sof;
  logic          o_eof;
  logic [CW-1:0] o_frame_cnt;
  logic [CW-1:0] o_drop_cnt;
  logic          o_line_err;

  cam_capture_multi #(.DATA_WIDTH(DW), .EXP_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .i_pclk(i_pclk), .i_rstn(i_rstn), .i_cfg_done(i_cfg_done),
    .i_vsync(i_vsync), .i_href(i_href), .i_data(i_data),
    .i_mode(i_mode), .i_decim(i_decim), .i_full(i_full),
    .o_wr(o_wr), .o_wdata(o_wdata), .o_sof(o_sof), .o_eof(o_eof),
    .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt), .o_line_err(o_line_err)
  );

  always #5 i_pclk = ~i_pclk;

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;
  int sof_seen = 0;
  int eof_seen = 0;
  logic [15:0] expq[$];
  logic [1:0]  m_mode;
  logic [1:0]  m_decim;
  int          m_line;
  int          exp_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input logic [1:0] md, input logic [7:0] hi,
                                            input logic [7:0] lo);
    logic [3:0] r, g, b;
    r = hi[7:4];
    g = {hi[2:0], lo[7]};
    b = lo[4:1];
    case (md)
      2'd1:    return {hi, lo};
      2'd2:    return {8'h00, hi};
      default: return {4'h0, r, g, b};
    endcase
  endfunction

  // Monitor: frame pulses and scoreboard pops on every FIFO write.
  always @(negedge i_pclk) begin
    if (i_rstn) begin
      if (o_sof) sof_seen++;
      if (o_eof) eof_seen++;
      if (o_wr) begin
        wr_seen++;
        if (expq.size() == 0) chk("spurious_wr", 32'(o_wr), 32'd0);
        else                  chk("wdata", 32'(o_wdata), 32'(expq.pop_front()));
      end
    end
  end

  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d, input logic fl);
    i_vsync = vs;
    i_href  = hr;
    i_data  = d;
    i_full  = fl;
    @(negedge i_pclk);
  endtask

  task automatic start_frame(input logic [1:0] md, input logic [1:0] dc);
    i_mode  = md;
    i_decim = dc;
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    m_mode  = (md == 2'd3) ? 2'd0 : md;
    m_decim = (dc == 2'd3) ? 2'd0 : dc;
    m_line  = 0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // kind 0: 0xF8/0x1F, kind 1: position-coded bytes, kind 2: YUYV 0x80/0x10
  task automatic send_line(input int npx, input int kind, input int full_from, input int full_n);
    int step;
    int kidx;
    step = 1 << m_decim;
    kidx = 0;
    for (int px = 0; px < npx; px++) begin
      logic [7:0] hi, lo;
      logic keep, fl;
      case (kind)
        0:       begin hi = 8'hF8; lo = 8'h1F; end
        1:       begin hi = 8'(m_line * 16 + px); lo = 8'(8'hC0 + px * 3); end
        default: begin hi = 8'h80; lo = 8'h10; end
      endcase
      keep = ((px % step) == 0) && ((m_line % step) == 0);
      fl   = keep && (kidx >= full_from) && (kidx < full_from + full_n);
      if (keep) kidx++;
      cyc(1'b0, 1'b1, hi, 1'b0);
      cyc(1'b0, 1'b1, lo, fl);
      if (keep && !fl) expq.push_back(model_pix(m_mode, hi, lo));
      if (keep && fl)  exp_drop++;
    end
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    m_line++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 20) begin
      @(negedge i_pclk);
      n++;
    end
    repeat (2) @(negedge i_pclk);
    chk(tag, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int w0, s0, e0;
    i_rstn = 1'b0; i_cfg_done = 1'b0; i_vsync = 1'b0; i_href = 1'b0;
    i_data = 8'h00; i_mode = 2'd0; i_decim = 2'd0; i_full = 1'b0;
    m_mode = 2'd0; m_decim = 2'd0; m_line = 0; exp_drop = 0;
    repeat (3) @(negedge i_pclk);
    chk("rst_wr", 32'(o_wr), 32'd0);
    chk("rst_wdata", 32'(o_wdata), 32'd0);
    chk("rst_sof", 32'(o_sof), 32'd0);
    chk("rst_eof", 32'(o_eof), 32'd0);
    chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
    chk("rst_line_err", 32'(o_line_err), 32'd0);
    i_rstn = 1'b1;
    i_cfg_done = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Frame A: mode0, full rate, 2 lines of 4 px
    w0 = wr_seen;
    start_frame(2'd0, 2'd0);
    chk("a_sof", 32'(sof_seen), 32'd1);
    for (int l = 0; l < 2; l++) send_line(4, 0, 0, 0);
    drain("a_drain");
    chk("a_writes", 32'(wr_seen - w0), 32'd8);
    chk("a_wdata_hold", 32'(o_wdata), 32'h0F0F);
    chk("a_line_err", 32'(o_line_err), 32'd0);
    chk("a_frame_cnt", 32'(o_frame_cnt), 32'd0);

    // Frame B: mode1 raw, 1/2 decimation, 8x4
    start_frame(2'd1, 2'd1);
    chk("b_eof", 32'(eof_seen), 32'd1);
    chk("b_sof", 32'(sof_seen), 32'd2);
    chk("b_frame_cnt", 32'(o_frame_cnt), 32'd1);
    w0 = wr_seen;
    for (int l = 0; l < 4; l++) send_line(8, 1, 0, 0);
    drain("b_drain");
    chk("b_writes", 32'(wr_seen - w0), 32'd8);
    chk("b_line_err", 32'(o_line_err), 32'd1);

    // Frame C: mode2 Y-only, mid-frame mode change, 3 drops on full
    start_frame(2'd2, 2'd0);
    chk("c_frame_cnt", 32'(o_frame_cnt), 32'd2);
    chk("c_line_err_clr", 32'(o_line_err), 32'd0);
    w0 = wr_seen;
    exp_drop = 0;
    send_line(4, 2, 0, 0);
    i_mode = 2'd1;
    send_line(4, 2, 0, 3);
    drain("c_drain");
    chk("c_writes", 32'(wr_seen - w0), 32'd5);
    chk("c_drop_cnt", 32'(o_drop_cnt), 32'(exp_drop));
    chk("c_wdata_y", 32'(o_wdata), 32'h0080);
    chk("c_line_err", 32'(o_line_err), 32'd0);

    // Frame D: drop counter clears, short line flags error
    start_frame(2'd0, 2'd0);
    chk("d_drop_clr", 32'(o_drop_cnt), 32'd0);
    chk("d_frame_cnt", 32'(o_frame_cnt), 32'd3);
    chk("d_eof", 32'(eof_seen), 32'd3);
    send_line(3, 0, 0, 0);
    drain("d_drain");
    chk("d_line_err", 32'(o_line_err), 32'd1);
    send_line(4, 0, 0, 0);
    drain("d_drain2");
    chk("d_line_err_sticky", 32'(o_line_err), 32'd1);

    // Reset in the cycle a write is being presented
    cyc(1'b0, 1'b1, 8'h12, 1'b0);
    cyc(1'b0, 1'b1, 8'h34, 1'b0);
    @(posedge i_pclk);
    #1;
    chk("pre_rst_wr", 32'(o_wr), 32'd1);
    chk("pre_rst_wdata", 32'(o_wdata), 32'(model_pix(2'd0, 8'h12, 8'h34)));
    i_rstn = 1'b0;
    #1;
    chk("rst_async_wr", 32'(o_wr), 32'd0);
    chk("rst_async_frame_cnt", 32'(o_frame_cnt), 32'd0);
    chk("rst_async_line_err", 32'(o_line_err), 32'd0);
    expq.delete();
    @(negedge i_pclk);
    i_href = 1'b0;
    repeat (2) @(negedge i_pclk);
    i_rstn = 1'b1;

    // href outside the active region must not write
    w0 = wr_seen;
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'(k + 1), 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("idle_href_writes", 32'(wr_seen - w0), 32'd0);

    // cfg_done dropped mid-frame: no eof, frame count unchanged
    s0 = sof_seen;
    e0 = eof_seen;
    start_frame(2'd0, 2'd0);
    send_line(4, 0, 0, 0);
    drain("e_drain");
    i_cfg_done = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    i_cfg_done = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    start_frame(2'd0, 2'd0);
    chk("e_no_eof", 32'(eof_seen - e0), 32'd0);
    chk("e_sofs", 32'(sof_seen - s0), 32'd2);
    chk("e_frame_cnt", 32'(o_frame_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
